// File: rtl/pcg32_stream.sv
// PCG32 (XSH-RR) random sample generator with reseed handshake and an output FIFO.
// The generator runs a three-step seeding sequence, then pushes one sample per cycle while the FIFO has room.
module pcg32_stream #(
    parameter int          DEPTH        = 4,
    parameter logic [63:0] DEFAULT_SEED = 64'd42,
    parameter logic [63:0] DEFAULT_SEQ  = 64'd54
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seed_valid,
    output logic                         seed_ready,
    input  logic [63:0]                  seed_state,
    input  logic [63:0]                  seed_seq,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   out_level
);

    localparam int          LW   = $clog2(DEPTH + 1);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [63:0] MULT = 64'd6364136223846793005;

    typedef enum logic [1:0] {
        ST_SEED1 = 2'd0,
        ST_SEED2 = 2'd1,
        ST_SEED3 = 2'd2,
        ST_RUN   = 2'd3
    } fsm_t;

    function automatic logic [63:0] pcg_step(input logic [63:0] s, input logic [63:0] inc);
        return (s * MULT) + inc;
    endfunction

    // Rotating the doubled word keeps r = 0 free of any shift-by-32 term.
    function automatic logic [31:0] pcg_xsh_rr(input logic [63:0] s);
        logic [31:0] x;
        logic [4:0]  r;
        x = 32'(((s >> 18) ^ s) >> 27);
        r = s[63:59];
        return 32'({x, x} >> r);
    endfunction

    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [63:0]       r_state;
    logic [63:0]       w_state_nxt;
    logic [63:0]       r_inc;
    logic [63:0]       r_seed;
    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_seed_acc;
    logic [31:0]       w_sample;
    logic              w_unused_seq_msb;

    assign w_unused_seq_msb = seed_seq[63];
    assign w_full           = (r_count == LW'(DEPTH));
    assign w_pop            = (r_count != {LW{1'b0}}) && out_ready;
    assign w_seed_acc       = seed_valid && (r_fsm == ST_RUN);
    assign w_sample         = pcg_xsh_rr(r_state);

    assign seed_ready = (r_fsm == ST_RUN);
    assign out_valid  = (r_count != {LW{1'b0}});
    assign out_level  = r_count;
    assign out_data   = (r_count != {LW{1'b0}}) ? r_mem[r_rd_ptr] : 32'd0;

    // Next-state logic for the seeding sequence and the generator state.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (w_seed_acc) begin
            w_fsm_nxt   = ST_SEED1;
            w_state_nxt = 64'd0;
        end else begin
            case (r_fsm)
                ST_SEED1: begin
                    w_state_nxt = pcg_step(r_state, r_inc);
                    w_fsm_nxt   = ST_SEED2;
                end
                ST_SEED2: begin
                    w_state_nxt = r_state + r_seed;
                    w_fsm_nxt   = ST_SEED3;
                end
                ST_SEED3: begin
                    w_state_nxt = pcg_step(r_state, r_inc);
                    w_fsm_nxt   = ST_RUN;
                end
                ST_RUN: begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_state_nxt = pcg_step(r_state, r_inc);
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                default: begin
                    w_fsm_nxt   = ST_SEED1;
                    w_state_nxt = 64'd0;
                end
            endcase
        end
    end

    // Generator registers: FSM, LCG state, increment and pending seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_SEED1;
            r_state <= 64'd0;
            r_inc   <= {DEFAULT_SEQ[62:0], 1'b1};
            r_seed  <= DEFAULT_SEED;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            if (w_seed_acc) begin
                r_inc  <= {seed_seq[62:0], 1'b1};
                r_seed <= seed_state;
            end
        end
    end

    // FIFO pointers and occupancy; an accepted reseed flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else if (w_seed_acc) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sample storage; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sample;
        end
    end

endmodule
